ctrl_pipe: RTL and testbench
============================

CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; ports listed below.
REQ-002 clk  in  1  pipeline clock, all state rises on posedge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 id_wb  in  2  decode WB bundle: [1]=MemtoReg, [0]=RegWrite.
REQ-005 id_mem  in  3  decode MEM bundle: [2]=Branch, [1]=MemRead, [0]=MemWrite.
REQ-006 id_ex  in  4  decode EX bundle: [3]=RegDst, [2]=ALUOp[0], [1]=ALUSrc, [0]=ALUOp[1].
REQ-007 id_valid  in  1  bundle and register numbers in ID are valid this cycle.
REQ-008 id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-009 mem_zero  in  1  ALU zero flag of the instruction in MEM.
REQ-010 ex_reg_dst, ex_alu_src  out  1 each; ex_alu_op  out  2  EX-stage controls.
REQ-011 mem_branch, mem_mem_read, mem_mem_write  out  1 each  MEM-stage controls.
REQ-012 wb_reg_write, wb_mem_to_reg  out  1 each  WB-stage controls.
REQ-013 pc_src  out  1  branch taken; hazard_stall  out  1  hold PC and IF/ID.

Function
REQ-014 Three registered stages SHALL exist: ID/EX (wb, mem, ex fields, rt), EX/MEM (wb, mem fields), MEM/WB (wb fields).
REQ-015 Latency: a bundle accepted at edge N SHALL drive EX outputs after N, MEM outputs after N+1, WB outputs after N+2.
REQ-016 EX outputs SHALL be unpacked per REQ-006 (ex_alu_op = {ALUOp[1], ALUOp[0]}); MEM and WB outputs per REQ-005/REQ-004.
REQ-017 pc_src SHALL be combinational: mem_branch AND mem_zero.
REQ-018 hazard_stall SHALL be combinational: id_valid AND ID/EX MemRead AND ID/EX rt != 0 AND (ID/EX rt == id_rs OR ID/EX rt == id_rt) AND NOT pc_src.
REQ-019 ID/EX SHALL load an all-zero bubble (controls and rt) when pc_src, hazard_stall, or NOT id_valid; otherwise the decode bundle and id_rt.
REQ-020 EX/MEM SHALL load an all-zero bubble when pc_src; otherwise the ID/EX contents.
REQ-021 MEM/WB SHALL load EX/MEM wb fields every cycle unconditionally (branch instruction itself and older work complete).
REQ-022 pc_src and hazard_stall both true SHALL never occur; pc_src has priority (REQ-018).
REQ-023 A stall SHALL last exactly one cycle per load-use pair; the bubble clears MemRead in ID/EX, dropping hazard_stall.
REQ-024 Undefined or unused bundle values SHALL be carried unchanged; the block performs no opcode checking.

Reset
REQ-025 While rst_n=0, all three stage registers SHALL be zero, making every output 0 asynchronously.
REQ-026 Reset assertion mid-stream SHALL discard all in-flight bundles; first capture after release is the next edge with rst_n=1.

Configuration
REQ-027 Macro CTRL_PIPE_HAZARD_EN defined: load-use detection per REQ-018/REQ-019 included.
REQ-028 Macro CTRL_PIPE_HAZARD_EN undefined: hazard_stall SHALL be tied 0, ID/EX rt storage omitted, no hazard bubbles; pc_src flush unchanged.

Verification
REQ-029 id_wb=01, id_mem=000, id_ex=1001, valid at edge 0 -> after edge 0 ex_reg_dst=1, ex_alu_op=10, ex_alu_src=0; after edge 2 wb_reg_write=1, wb_mem_to_reg=0.
REQ-030 LW (wb=11, mem=010, ex=0010, rt=5) then id_rs=5 next cycle -> hazard_stall=1 one cycle, EX outputs all 0 for one cycle, dependent bundle reaches EX one cycle later; repeat with rt=0 -> no stall.
REQ-031 BEQ (mem=100, ex=0100) with mem_zero=1 in its MEM cycle -> pc_src=1, next-edge EX and MEM outputs all 0; same with mem_zero=0 -> pc_src=0, no bubbles.
REQ-032 pc_src=1 coincident with a load-use match in ID -> hazard_stall=0, EX and MEM bubbled.
REQ-033 rst_n driven low between edges with three bundles in flight -> every output 0 before next edge; after release, empty pipe.
REQ-034 Build without CTRL_PIPE_HAZARD_EN, rerun REQ-030 stimulus -> hazard_stall stays 0, no bubble inserted.

Source files
------------

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control-bundle pipeline for a five-stage in-order core.
// Carries decoded WB/MEM/EX control bundles through the ID/EX, EX/MEM and
// MEM/WB registers, resolves taken branches in MEM (pc_src) and, optionally,
// detects load-use hazards in ID (hazard_stall).
//
// Build option: define CTRL_PIPE_HAZARD_EN to include load-use detection.
// Without it hazard_stall is tied low and the ID/EX rt field is not stored.
module ctrl_pipe (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] id_wb,      // [1]=MemtoReg, [0]=RegWrite
   input  logic [2:0] id_mem,     // [2]=Branch, [1]=MemRead, [0]=MemWrite
   input  logic [3:0] id_ex,      // [3]=RegDst, [2]=ALUOp[0], [1]=ALUSrc, [0]=ALUOp[1]
   input  logic       id_valid,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       mem_zero,
   output logic       ex_reg_dst,
   output logic       ex_alu_src,
   output logic [1:0] ex_alu_op,
   output logic       mem_branch,
   output logic       mem_mem_read,
   output logic       mem_mem_write,
   output logic       wb_reg_write,
   output logic       wb_mem_to_reg,
   output logic       pc_src,
   output logic       hazard_stall
);

   typedef struct packed {
      logic [1:0] wb;
      logic [2:0] mem;
      logic [3:0] ex;
   } idex_t;

   typedef struct packed {
      logic [1:0] wb;
      logic [2:0] mem;
   } exmem_t;

   idex_t      idex_q,  idex_d;
   exmem_t     exmem_q, exmem_d;
   logic [1:0] memwb_q, memwb_d;
   logic       idex_load;

   // Stage-register fields driving the per-stage control outputs.
   assign ex_reg_dst    = idex_q.ex[3];
   assign ex_alu_op     = {idex_q.ex[0], idex_q.ex[2]};
   assign ex_alu_src    = idex_q.ex[1];
   assign mem_branch    = exmem_q.mem[2];
   assign mem_mem_read  = exmem_q.mem[1];
   assign mem_mem_write = exmem_q.mem[0];
   assign wb_reg_write  = memwb_q[0];
   assign wb_mem_to_reg = memwb_q[1];

   // Branch resolves in MEM; a taken branch flushes the two younger stages.
   assign pc_src = exmem_q.mem[2] & mem_zero;

   // ID may enter EX only when it is valid, not flushed and not stalled.
   assign idex_load = id_valid & ~pc_src & ~hazard_stall;

`ifdef CTRL_PIPE_HAZARD_EN
   logic [4:0] idex_rt_q, idex_rt_d;

   // Load in EX whose destination feeds a source of the instruction in ID;
   // a taken branch overrides, since the instruction in ID is being flushed.
   assign hazard_stall = id_valid & idex_q.mem[1] & (idex_rt_q != 5'd0)
                       & ((idex_rt_q == id_rs) | (idex_rt_q == id_rt))
                       & ~pc_src;

   // Destination register of the instruction entering EX; zero on a bubble.
   always_comb begin
      idex_rt_d = 5'd0;
      if (idex_load) idex_rt_d = id_rt;
   end

   // ID/EX rt register, cleared by reset like the control fields.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) idex_rt_q <= 5'd0;
      else        idex_rt_q <= idex_rt_d;
   end
`else
   logic unused_rs_rt;

   assign hazard_stall = 1'b0;
   assign unused_rs_rt = ^{id_rs, id_rt};
`endif

   // Next state of the three stage registers: bubbles on flush/stall/invalid.
   always_comb begin
      // NOTE: every variable gets a default before the ifs so no latch is inferred.
      idex_d  = '0;
      exmem_d = '0;
      memwb_d = exmem_q.wb;
      if (idex_load) begin
         idex_d.wb  = id_wb;
         idex_d.mem = id_mem;
         idex_d.ex  = id_ex;
      end
      if (!pc_src) begin
         exmem_d.wb  = idex_q.wb;
         exmem_d.mem = idex_q.mem;
      end
   end

   // Stage registers; reset empties the whole pipe asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state updates use non-blocking assignments so all stages shift on the same edge.
      if (!rst_n) begin
         idex_q  <= '0;
         exmem_q <= '0;
         memwb_q <= 2'b00;
      end else begin
         idex_q  <= idex_d;
         exmem_q <= exmem_d;
         memwb_q <= memwb_d;
      end
   end

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed, table-driven bench for ctrl_pipe.
// Each step drives the ID inputs just after a falling edge, samples all
// outputs 1 ns later (mid-cycle) and then lets the rising edge capture.
// Expected output word layout (11 bits):
//   {ex_reg_dst, ex_alu_op[1:0], ex_alu_src,
//    mem_branch, mem_mem_read, mem_mem_write,
//    wb_reg_write, wb_mem_to_reg, pc_src, hazard_stall}
// Load-use expectations follow the CTRL_PIPE_HAZARD_EN build option.
module tb_ctrl_pipe;

`ifdef CTRL_PIPE_HAZARD_EN
   localparam logic HZ = 1'b1;
`else
   localparam logic HZ = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic [1:0] id_wb;
   logic [2:0] id_mem;
   logic [3:0] id_ex;
   logic       id_valid;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       mem_zero;
   logic       ex_reg_dst;
   logic       ex_alu_src;
   logic [1:0] ex_alu_op;
   logic       mem_branch;
   logic       mem_mem_read;
   logic       mem_mem_write;
   logic       wb_reg_write;
   logic       wb_mem_to_reg;
   logic       pc_src;
   logic       hazard_stall;

   int errors = 0;
   int checks = 0;

   ctrl_pipe dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .id_wb         (id_wb),
      .id_mem        (id_mem),
      .id_ex         (id_ex),
      .id_valid      (id_valid),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .mem_zero      (mem_zero),
      .ex_reg_dst    (ex_reg_dst),
      .ex_alu_src    (ex_alu_src),
      .ex_alu_op     (ex_alu_op),
      .mem_branch    (mem_branch),
      .mem_mem_read  (mem_mem_read),
      .mem_mem_write (mem_mem_write),
      .wb_reg_write  (wb_reg_write),
      .wb_mem_to_reg (wb_mem_to_reg),
      .pc_src        (pc_src),
      .hazard_stall  (hazard_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [1:0]  wb;
      logic [2:0]  mem;
      logic [3:0]  ex;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic        zero;
      logic [10:0] exp;
   } vec_t;

   localparam int NV = 12;
   vec_t tbl [NV];

   function automatic logic [10:0] outs();
      return {ex_reg_dst, ex_alu_op, ex_alu_src, mem_branch, mem_mem_read,
              mem_mem_write, wb_reg_write, wb_mem_to_reg, pc_src, hazard_stall};
   endfunction

   task automatic check(input string name, input logic [10:0] exp);
      logic [10:0] got;
      got = outs();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%b expected=%b (rd,op2,src,br,mr,mw,rw,m2r,pc,st)",
                  name, got, exp);
      end
   endtask

   // Drive one ID cycle at a falling edge, check mid-cycle, wait for next fall.
   task automatic step(input logic v, input logic [1:0] wb, input logic [2:0] mem,
                       input logic [3:0] ex, input logic [4:0] rs, input logic [4:0] rt,
                       input logic z, input logic [10:0] exp, input string name);
      id_valid = v;
      id_wb    = wb;
      id_mem   = mem;
      id_ex    = ex;
      id_rs    = rs;
      id_rt    = rt;
      mem_zero = z;
      #1;
      check(name, exp);
      @(negedge clk);
   endtask

   task automatic idle(input logic [10:0] exp, input string name);
      step(1'b0, 2'b00, 3'b000, 4'b0000, 5'd0, 5'd0, 1'b0, exp, name);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

   initial begin
      // Straight-line bundles: latency, field unpacking, values carried as-is.
      tbl[0]  = '{1'b1, 2'b01, 3'b000, 4'b1001, 5'd0, 5'd0, 1'b0, 11'b0_00_0_000_00_0_0};
      tbl[1]  = '{1'b0, 2'b00, 3'b000, 4'b0000, 5'd0, 5'd0, 1'b0, 11'b1_10_0_000_00_0_0};
      tbl[2]  = '{1'b0, 2'b00, 3'b000, 4'b0000, 5'd0, 5'd0, 1'b0, 11'b0_00_0_000_00_0_0};
      tbl[3]  = '{1'b0, 2'b00, 3'b000, 4'b0000, 5'd0, 5'd0, 1'b0, 11'b0_00_0_000_10_0_0};
      tbl[4]  = '{1'b0, 2'b00, 3'b000, 4'b0000, 5'd0, 5'd0, 1'b0, 11'b0_00_0_000_00_0_0};
      tbl[5]  = '{1'b1, 2'b11, 3'b011, 4'b1111, 5'd0, 5'd0, 1'b0, 11'b0_00_0_000_00_0_0};
      tbl[6]  = '{1'b1, 2'b10, 3'b001, 4'b0110, 5'd0, 5'd0, 1'b0, 11'b1_11_1_000_00_0_0};
      tbl[7]  = '{1'b0, 2'b00, 3'b000, 4'b0000, 5'd0, 5'd0, 1'b0, 11'b0_01_1_011_00_0_0};
      tbl[8]  = '{1'b0, 2'b00, 3'b000, 4'b0000, 5'd0, 5'd0, 1'b0, 11'b0_00_0_001_11_0_0};
      tbl[9]  = '{1'b0, 2'b00, 3'b000, 4'b0000, 5'd0, 5'd0, 1'b0, 11'b0_00_0_000_01_0_0};
      tbl[10] = '{1'b0, 2'b11, 3'b111, 4'b1111, 5'd0, 5'd0, 1'b0, 11'b0_00_0_000_00_0_0};
      tbl[11] = '{1'b0, 2'b00, 3'b000, 4'b0000, 5'd0, 5'd0, 1'b0, 11'b0_00_0_000_00_0_0};

      // Reset held with a live, branch-looking bundle in ID: all outputs 0.
      rst_n    = 1'b0;
      id_valid = 1'b1;
      id_wb    = 2'b11;
      id_mem   = 3'b111;
      id_ex    = 4'b1111;
      id_rs    = 5'd3;
      id_rt    = 5'd3;
      mem_zero = 1'b1;
      @(posedge clk);
      #2;
      check("reset_hold", 11'b0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++)
         step(tbl[i].valid, tbl[i].wb, tbl[i].mem, tbl[i].ex, tbl[i].rs, tbl[i].rt,
              tbl[i].zero, tbl[i].exp, $sformatf("vec%0d", i));

      // Taken branch: the two younger bundles are flushed, the branch retires.
      step(1'b1, 2'b00, 3'b100, 4'b0100, 5'd0, 5'd0, 1'b0, 11'b0_00_0_000_00_0_0, "bt_beq");
      step(1'b1, 2'b01, 3'b000, 4'b1001, 5'd0, 5'd0, 1'b0, 11'b0_01_0_000_00_0_0, "bt_x");
      step(1'b1, 2'b11, 3'b000, 4'b0011, 5'd0, 5'd0, 1'b1, 11'b1_10_0_100_00_1_0, "bt_taken");
      step(1'b0, 2'b00, 3'b000, 4'b0000, 5'd0, 5'd0, 1'b1, 11'b0_00_0_000_00_0_0, "bt_flush1");
      idle(11'b0_00_0_000_00_0_0, "bt_flush2");

      // Not-taken branch: no bubbles, everything drains in order.
      step(1'b1, 2'b00, 3'b100, 4'b0100, 5'd0, 5'd0, 1'b0, 11'b0_00_0_000_00_0_0, "bn_beq");
      step(1'b1, 2'b01, 3'b000, 4'b1001, 5'd0, 5'd0, 1'b0, 11'b0_01_0_000_00_0_0, "bn_x");
      step(1'b1, 2'b11, 3'b000, 4'b0011, 5'd0, 5'd0, 1'b0, 11'b1_10_0_100_00_0_0, "bn_mem");
      idle(11'b0_10_1_000_00_0_0, "bn_d1");
      idle(11'b0_00_0_000_10_0_0, "bn_d2");
      idle(11'b0_00_0_000_11_0_0, "bn_d3");
      idle(11'b0_00_0_000_00_0_0, "bn_d4");

      // Load-use on rs: one-cycle stall and bubble when detection is built in.
      step(1'b1, 2'b11, 3'b010, 4'b0010, 5'd0, 5'd5, 1'b0, 11'b0_00_0_000_00_0_0, "lu_lw");
      step(1'b1, 2'b01, 3'b000, 4'b1001, 5'd5, 5'd7, 1'b0, {10'b0_00_1_000_00_0, HZ}, "lu_dep");
`ifdef CTRL_PIPE_HAZARD_EN
      step(1'b1, 2'b01, 3'b000, 4'b1001, 5'd5, 5'd7, 1'b0, 11'b0_00_0_010_00_0_0, "lu_bubble");
      idle(11'b1_10_0_000_11_0_0, "lu_d1");
      idle(11'b0_00_0_000_00_0_0, "lu_d2");
      idle(11'b0_00_0_000_10_0_0, "lu_d3");
`else
      idle(11'b1_10_0_010_00_0_0, "lu_nobubble");
      idle(11'b0_00_0_000_11_0_0, "lu_d1");
      idle(11'b0_00_0_000_10_0_0, "lu_d2");
      idle(11'b0_00_0_000_00_0_0, "lu_d3");
`endif

      // Load to r0 never stalls.
      step(1'b1, 2'b11, 3'b010, 4'b0010, 5'd0, 5'd0, 1'b0, 11'b0_00_0_000_00_0_0, "r0_lw");
      step(1'b1, 2'b01, 3'b000, 4'b1001, 5'd0, 5'd0, 1'b0, 11'b0_00_1_000_00_0_0, "r0_dep");
      idle(11'b1_10_0_010_00_0_0, "r0_d1");
      idle(11'b0_00_0_000_11_0_0, "r0_d2");
      idle(11'b0_00_0_000_10_0_0, "r0_d3");

      // Load-use matching on rt only.
      step(1'b1, 2'b11, 3'b010, 4'b0010, 5'd0, 5'd9, 1'b0, 11'b0_00_0_000_00_0_0, "rt_lw");
      step(1'b1, 2'b00, 3'b000, 4'b1001, 5'd3, 5'd9, 1'b0, {10'b0_00_1_000_00_0, HZ}, "rt_dep");
`ifdef CTRL_PIPE_HAZARD_EN
      idle(11'b0_00_0_010_00_0_0, "rt_d1");
`else
      idle(11'b1_10_0_010_00_0_0, "rt_d1");
`endif
      idle(11'b0_00_0_000_11_0_0, "rt_d2");
      idle(11'b0_00_0_000_00_0_0, "rt_d3");

      // Taken branch coincident with a load-use match: flush wins, no stall.
      step(1'b1, 2'b00, 3'b100, 4'b0100, 5'd0, 5'd0, 1'b0, 11'b0_00_0_000_00_0_0, "pr_beq");
      step(1'b1, 2'b11, 3'b010, 4'b0010, 5'd0, 5'd6, 1'b0, 11'b0_01_0_000_00_0_0, "pr_lw");
      step(1'b1, 2'b01, 3'b000, 4'b1001, 5'd6, 5'd0, 1'b1, 11'b0_00_1_100_00_1_0, "pr_both");
      idle(11'b0_00_0_000_00_0_0, "pr_d1");
      idle(11'b0_00_0_000_00_0_0, "pr_d2");

      // Reset mid-cycle with three bundles in flight.
      step(1'b1, 2'b11, 3'b111, 4'b1111, 5'd0, 5'd0, 1'b0, 11'b0_00_0_000_00_0_0, "rs_a1");
      step(1'b1, 2'b11, 3'b111, 4'b1111, 5'd0, 5'd0, 1'b0, 11'b1_11_1_000_00_0_0, "rs_a2");
      step(1'b1, 2'b11, 3'b111, 4'b1111, 5'd0, 5'd0, 1'b0, 11'b1_11_1_111_00_0_0, "rs_a3");
      id_valid = 1'b0;
      id_wb    = 2'b00;
      id_mem   = 3'b000;
      id_ex    = 4'b0000;
      #1;
      check("rs_full", 11'b1_11_1_111_11_0_0);
      #1;
      rst_n    = 1'b0;
      mem_zero = 1'b1;
      #1;
      check("rs_async", 11'b0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 2'b01, 3'b000, 4'b1001, 5'd0, 5'd0, 1'b0, 11'b0_00_0_000_00_0_0, "rs_empty");
      idle(11'b1_10_0_000_00_0_0, "rs_first");
      idle(11'b0_00_0_000_00_0_0, "rs_d1");
      idle(11'b0_00_0_000_10_0_0, "rs_d2");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
